quad_encoder_reader: RTL and testbench

//  Input-side IO device: decodes a quadrature encoder (A/B/index) on Pmod JB into a signed position,

---
 rtl/quad_encoder_reader.sv | 155 +++++++++++++++
 tb/tb_quad_encoder_reader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_reader.sv
// Quadrature encoder reader: A/B/index pins -> position, velocity, status.
// Ports: clk, resetn, JB[2:0], rd_en/rd_sel -> data_out/data_valid; wr_en/data_in; err.
module quad_encoder_reader #(
  parameter int DEBOUNCE   = 4,
  parameter int VEL_WINDOW = 1000000,
  parameter bit INVERT_DIR = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  JB,
  input  logic        rd_en,
  input  logic [1:0]  rd_sel,
  input  logic        wr_en,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        err
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int WW = (VEL_WINDOW > 1) ? $clog2(VEL_WINDOW) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(VEL_WINDOW - 1);

  logic [2:0]         sync1;
  logic [2:0]         sync2;
  logic [2:0]         filt;
  logic [2:0][CW-1:0] cnt;

  logic [2:0]  prev;
  logic [1:0]  ph_now;
  logic [1:0]  ph_prev;
  logic [1:0]  ph_diff;
  logic        fwd;
  logic        rev;
  logic        bad;
  logic        up;
  logic        dn;
  logic        idx_rise;
  logic [31:0] step;

  logic [31:0] position;
  logic [31:0] velocity;
  logic [31:0] acc;
  logic [WW-1:0] win_cnt;
  logic        idx_seen;
  logic        dir;
  logic [31:0] status;
  logic [31:0] rd_word;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= '0;
      sync2 <= '0;
      filt  <= '0;
      cnt   <= '0;
    end else begin
      sync1 <= JB;
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Gray -> binary phase; the phase difference mod 4 gives the move.
  assign ph_now  = {filt[1], filt[1] ^ filt[0]};
  assign ph_prev = {prev[1], prev[1] ^ prev[0]};
  assign ph_diff = ph_now - ph_prev;

  always_comb begin
    fwd = 1'b0;
    rev = 1'b0;
    bad = 1'b0;
    unique case (1'b1)
      (ph_diff == 2'd1): fwd = 1'b1;
      (ph_diff == 2'd3): rev = 1'b1;
      (ph_diff == 2'd2): bad = 1'b1;
      default: ;
    endcase
  end

  assign up       = INVERT_DIR ? rev : fwd;
  assign dn       = INVERT_DIR ? fwd : rev;
  assign step     = up ? 32'd1 : (dn ? 32'hFFFF_FFFF : 32'd0);
  assign idx_rise = filt[2] & ~prev[2];

  assign status = {26'd0, filt, idx_seen, dir, err};

  always_comb begin
    rd_word = '0;
    unique case (1'b1)
      (rd_sel == 2'b00): rd_word = position;
      (rd_sel == 2'b01): rd_word = velocity;
      (rd_sel == 2'b10): rd_word = status;
      (rd_sel == 2'b11): rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev       <= '0;
      position   <= '0;
      velocity   <= '0;
      acc        <= '0;
      win_cnt    <= '0;
      idx_seen   <= 1'b0;
      dir        <= 1'b0;
      err        <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      prev <= filt;
      if (up) begin
        dir <= 1'b1;
      end else if (dn) begin
        dir <= 1'b0;
      end
      // A write overrides any step decoded in the same cycle.
      if (wr_en) begin
        position <= data_in;
        err      <= 1'b0;
        idx_seen <= 1'b0;
      end else begin
        position <= position + step;
        if (bad) begin
          err <= 1'b1;
        end
        if (idx_rise) begin
          idx_seen <= 1'b1;
        end
      end
      if (win_cnt == WIN_LAST) begin
        win_cnt  <= '0;
        velocity <= acc + step;
        acc      <= '0;
      end else begin
        win_cnt <= win_cnt + WW'(1);
        acc     <= acc + step;
      end
      data_valid <= rd_en;
      if (rd_en) begin
        data_out <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_quad_encoder_reader.sv
// Bench for quad_encoder_reader: directed cases plus random pins/reads/writes.
// Every cycle the DUT is compared with a behavioural model of the pin path.
module tb_quad_encoder_reader;

  localparam int D = 4;
  localparam int W = 100;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  JB;
  logic        rd_en;
  logic [1:0]  rd_sel;
  logic        wr_en;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        data_valid;
  logic        err;

  always #5 clk = ~clk;

  quad_encoder_reader #(
    .DEBOUNCE(D),
    .VEL_WINDOW(W),
    .INVERT_DIR(1'b0)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .JB(JB),
    .rd_en(rd_en),
    .rd_sel(rd_sel),
    .wr_en(wr_en),
    .data_in(data_in),
    .data_out(data_out),
    .data_valid(data_valid),
    .err(err)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Model: pins are seen two samples late; a pin's accepted level moves
  // once the last D seen samples agree with each other and differ from it.
  int          gidx [4] = '{0, 1, 3, 2};
  int          code [4] = '{0, 1, 3, 2};
  logic [2:0]  mh [0:D];
  logic [2:0]  mf;
  logic [2:0]  mprev;
  logic [31:0] mpos;
  logic [31:0] mvel;
  logic [31:0] macc;
  int          mwin;
  logic        merr;
  logic        mdir;
  logic        midx;
  logic        mval;
  logic [31:0] mdout;

  always @(posedge clk or negedge resetn) begin
    int          d;
    logic [31:0] st;
    logic        same;
    if (!resetn) begin
      for (int i = 0; i <= D; i++) mh[i] <= '0;
      mf    <= '0;
      mprev <= '0;
      mpos  <= '0;
      mvel  <= '0;
      macc  <= '0;
      mwin  <= 0;
      merr  <= 1'b0;
      mdir  <= 1'b0;
      midx  <= 1'b0;
      mval  <= 1'b0;
      mdout <= '0;
    end else begin
      mval <= rd_en;
      if (rd_en) begin
        case (rd_sel)
          2'd0:    mdout <= mpos;
          2'd1:    mdout <= mvel;
          2'd2:    mdout <= {26'd0, mf, midx, mdir, merr};
          default: mdout <= 32'd0;
        endcase
      end
      d  = (gidx[mf[1:0]] - gidx[mprev[1:0]] + 4) % 4;
      st = (d == 1) ? 32'd1 : ((d == 3) ? 32'hFFFF_FFFF : 32'd0);
      if (d == 1) mdir <= 1'b1;
      else if (d == 3) mdir <= 1'b0;
      if (wr_en) begin
        mpos <= data_in;
        merr <= 1'b0;
        midx <= 1'b0;
      end else begin
        mpos <= mpos + st;
        if (d == 2) merr <= 1'b1;
        if (mf[2] && !mprev[2]) midx <= 1'b1;
      end
      if (mwin == W - 1) begin
        mvel <= macc + st;
        macc <= '0;
        mwin <= 0;
      end else begin
        macc <= macc + st;
        mwin <= mwin + 1;
      end
      mprev <= mf;
      for (int b = 0; b < 3; b++) begin
        same = 1'b1;
        for (int i = 1; i <= D; i++)
          if (mh[i][b] != mh[1][b]) same = 1'b0;
        if (same && mh[1][b] != mf[b]) mf[b] <= mh[1][b];
      end
      for (int i = D; i > 0; i--) mh[i] <= mh[i-1];
      mh[0] <= JB;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("valid", {31'd0, data_valid}, {31'd0, mval});
      chk("err", {31'd0, err}, {31'd0, merr});
      if (mval) chk("rdata", data_out, mdout);
    end
  end

  int gi = 0;

  task automatic move(input int delta);
    gi = (gi + delta) & 3;
    JB[1:0] = 2'(code[gi]);
  endtask

  task automatic rd(input logic [1:0] sel, input logic [31:0] exp,
                    input string nm);
    @(negedge clk);
    rd_en  = 1'b1;
    rd_sel = sel;
    @(negedge clk);
    rd_en = 1'b0;
    chk(nm, data_out, exp);
    chk({nm, "_valid"}, {31'd0, data_valid}, 32'd1);
  endtask

  task automatic wr(input logic [31:0] v);
    @(negedge clk);
    wr_en   = 1'b1;
    data_in = v;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_win(input int v);
    int k = 0;
    while (mwin != v && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (mwin != v) chk("win_wait", mwin, v);
  endtask

  task automatic steps(input int n, input int delta, input int gap);
    for (int i = 0; i < n; i++) begin
      move(delta);
      repeat (gap) @(negedge clk);
    end
  endtask

  initial begin
    int r;
    resetn  = 1'b0;
    JB      = 3'b000;
    rd_en   = 1'b0;
    rd_sel  = 2'b00;
    wr_en   = 1'b0;
    data_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_dout", data_out, 32'd0);
    chk("rst_valid", {31'd0, data_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    cmp_on = 1'b1;
    resetn = 1'b1;

    rd(2'b00, 32'd0, "pos_reset");
    rd(2'b01, 32'd0, "vel_reset");
    rd(2'b10, 32'd0, "stat_reset");

    steps(8, 1, 20);
    rd(2'b00, 32'd8, "pos_fwd8");
    rd(2'b10, 32'h2, "stat_fwd");
    steps(3, 3, 20);
    rd(2'b00, 32'd5, "pos_rev3");

    @(negedge clk);
    JB[0] = ~JB[0];
    repeat (D - 1) @(negedge clk);
    JB[0] = ~JB[0];
    repeat (20) @(negedge clk);
    rd(2'b00, 32'd5, "pos_glitch");
    chk("err_glitch", {31'd0, err}, 32'd0);

    move(2);
    repeat (20) @(negedge clk);
    chk("err_jump", {31'd0, err}, 32'd1);
    rd(2'b00, 32'd5, "pos_jump");
    wr(32'h10);
    rd(2'b00, 32'd16, "pos_write");
    chk("err_clear", {31'd0, err}, 32'd0);

    wr(32'h7FFF_FFFF);
    move(1);
    repeat (20) @(negedge clk);
    rd(2'b00, 32'h8000_0000, "pos_wrap_hi");
    wr(32'h0);
    move(3);
    repeat (20) @(negedge clk);
    rd(2'b00, 32'hFFFF_FFFF, "pos_wrap_lo");

    repeat (20) @(negedge clk);
    wait_win(5);
    steps(10, 1, 7);
    wait_win(2);
    rd(2'b01, 32'd10, "vel_10");
    rd(2'b11, 32'd0, "sel11");

    move(1);
    repeat (6) @(negedge clk);
    wr_en   = 1'b1;
    data_in = 32'h1234;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (10) @(negedge clk);
    rd(2'b00, 32'h1234, "pos_wr_step");

    JB[2] = 1'b1;
    repeat (20) @(negedge clk);
    rd(2'b10, 32'h26 | (32'(code[gi]) << 3), "stat_idx");

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rd_en   = ($urandom_range(0, 99) < 30);
      rd_sel  = 2'($urandom);
      wr_en   = ($urandom_range(0, 99) < 3);
      data_in = $urandom;
      r = $urandom_range(0, 99);
      if (r < 8) move(1);
      else if (r < 14) move(3);
      else if (r < 15) move(2);
      else if (r < 17) JB[2] = ~JB[2];
      if (n % 1000 == 500) begin
        #2 resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
      end
    end
    rd_en = 1'b0;
    wr_en = 1'b0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
